// File: rtl/clook_pkg.sv
// clook_pkg: shared state encoding, slice width and subtractor width helper for clook_div
package clook_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam int SLICE_W = 4;
  function automatic int sub_w(input int w);
    return ((w + SLICE_W) / SLICE_W) * SLICE_W;
  endfunction
endpackage

// File: rtl/clook_sub4.sv
// clook_sub4: 4-bit borrow-lookahead subtractor slice, d = a - b - bin, bout = borrow out (ports a, b, bin -> d, bout)
module clook_sub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a & ~b;
  assign p = a ^ ~b;
  assign c[0] = ~bin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign d = p ^ c[3:0];
  assign bout = ~c[4];
endmodule

// File: rtl/clook_div.sv
// clook_div: sequential restoring divider (clk, rst, start, dividend, divisor -> busy, done, quotient, remainder, div_by_zero)
module clook_div
  import clook_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SW = sub_w(WIDTH);
  localparam int NS = SW / SLICE_W;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dsh, dvs, r, r_nxt, q_nxt;
  logic [WIDTH-2:0] qsh;
  logic [WIDTH:0] t;
  logic [SW-1:0] sa, sb, sd;
  logic [NS:0] bc;
  logic qbit, unused_hi;
  assign t = {r, dsh[WIDTH-1]};
  assign sa = SW'(t);
  assign sb = SW'(dvs);
  assign bc[0] = 1'b0;
  for (genvar s = 0; s < NS; s++) begin : g_slice
    clook_sub4 u_sub (
      .a(sa[s*SLICE_W +: SLICE_W]),
      .b(sb[s*SLICE_W +: SLICE_W]),
      .bin(bc[s]),
      .d(sd[s*SLICE_W +: SLICE_W]),
      .bout(bc[s+1])
    );
  end
  // borrow out of the top slice means the trial subtraction failed: restore
  assign qbit = ~bc[NS];
  assign r_nxt = qbit ? sd[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_nxt = {qsh, qbit};
  assign unused_hi = ^sd[SW-1:WIDTH];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dsh <= '0;
      dvs <= '0;
      r <= '0;
      qsh <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (divisor == '0) begin
            state <= FIN;
            done <= 1'b1;
            quotient <= '1;
            remainder <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            state <= RUN;
            dsh <= dividend;
            dvs <= divisor;
            r <= '0;
            qsh <= '0;
            cnt <= CNT_W'(WIDTH);
          end
        end
        RUN: begin
          dsh <= {dsh[WIDTH-2:0], 1'b0};
          r <= r_nxt;
          qsh <= q_nxt[WIDTH-2:0];
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= FIN;
            done <= 1'b1;
            quotient <= q_nxt;
            remainder <= r_nxt;
            div_by_zero <= 1'b0;
          end
        end
        FIN: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clook_div.sv
// tb_clook_div: scoreboard bench for clook_div at WIDTH=8 and WIDTH=13
module tb_clook_div;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic start8 = 1'b0, busy8, done8, dz8;
  logic [7:0] dividend8 = '0, divisor8 = '0, quo8, rem8;
  logic start13 = 1'b0, busy13, done13, dz13;
  logic [12:0] dividend13 = '0, divisor13 = '0, quo13, rem13;
  clook_div #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8), .div_by_zero(dz8)
  );
  clook_div #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .dividend(dividend13), .divisor(divisor13),
    .busy(busy13), .done(done13), .quotient(quo13), .remainder(rem13), .div_by_zero(dz13)
  );
  typedef struct {
    logic [15:0] a, b, q, r;
    logic dz;
    int cyc;
  } exp_t;
  exp_t q8[$], q13[$];
  exp_t e8, e13;
  int cyc = 0, n_chk = 0, n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int w, input int k);
    exp_t e;
    logic [15:0] one = 16'd1;
    e.a = a;
    e.b = b;
    e.dz = (b == 0);
    e.q = e.dz ? (one << w) - 16'd1 : a / b;
    e.r = e.dz ? a : a % b;
    e.cyc = e.dz ? k : k + w;
    return e;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (!rst && done8) begin
    if (q8.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done8: unexpected done pulse (cycle %0d)", cyc);
    end else begin
      e8 = q8.pop_front();
      chk("quo8", 32'(quo8), 32'(e8.q));
      chk("rem8", 32'(rem8), 32'(e8.r));
      chk("dz8", 32'(dz8), 32'(e8.dz));
      chk("lat8", cyc, e8.cyc);
      if (!e8.dz) begin
        chk("ident8", 32'(quo8) * 32'(e8.b) + 32'(rem8), 32'(e8.a));
        chk("rlt8", 32'(32'(rem8) < 32'(e8.b)), 32'd1);
      end
    end
  end
  always @(negedge clk) if (!rst && done13) begin
    if (q13.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done13: unexpected done pulse (cycle %0d)", cyc);
    end else begin
      e13 = q13.pop_front();
      chk("quo13", 32'(quo13), 32'(e13.q));
      chk("rem13", 32'(rem13), 32'(e13.r));
      chk("dz13", 32'(dz13), 32'(e13.dz));
      chk("lat13", cyc, e13.cyc);
      if (!e13.dz) chk("ident13", 32'(quo13) * 32'(e13.b) + 32'(rem13), 32'(e13.a));
    end
  end
  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while ((busy8 || done8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_wait8", 32'(busy8), 32'd0);
    start8 = 1'b1;
    dividend8 = a;
    divisor8 = b;
    @(posedge clk);
    #1;
    q8.push_back(model(16'(a), 16'(b), 8, cyc));
    chk("busy_rise8", 32'(busy8), 32'd1);
    start8 = 1'b0;
  endtask
  task automatic b2b8(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!done8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("done_wait8", 32'(done8), 32'd1);
    // start raised during the done cycle and held: only the following edge may accept it
    start8 = 1'b1;
    dividend8 = a;
    divisor8 = b;
    @(posedge clk);
    @(posedge clk);
    #1;
    q8.push_back(model(16'(a), 16'(b), 8, cyc));
    chk("busy_b2b8", 32'(busy8), 32'd1);
    start8 = 1'b0;
  endtask
  task automatic issue13(input logic [12:0] a, input logic [12:0] b);
    int n = 0;
    @(negedge clk);
    while ((busy13 || done13) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_wait13", 32'(busy13), 32'd0);
    start13 = 1'b1;
    dividend13 = a;
    divisor13 = b;
    @(posedge clk);
    #1;
    q13.push_back(model(16'(a), 16'(b), 13, cyc));
    chk("busy_rise13", 32'(busy13), 32'd1);
    start13 = 1'b0;
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_quo", 32'(quo8), 32'd0);
    chk("rst_rem", 32'(rem8), 32'd0);
    chk("rst_flags", {29'd0, busy8, done8, dz8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue8(8'd200, 8'd7);
    issue8(8'd255, 8'd1);
    issue8(8'd5, 8'd9);
    issue8(8'd0, 8'd3);
    issue8(8'd77, 8'd0);
    issue8(8'd10, 8'd3);
    n = 0;
    while (busy8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("hold_quo", 32'(quo8), 32'd3);
    chk("hold_rem", 32'(rem8), 32'd1);
    chk("hold_dz", 32'(dz8), 32'd0);
    issue8(8'd100, 8'd10);
    repeat (3) @(negedge clk);
    start8 = 1'b1;
    dividend8 = 8'd50;
    divisor8 = 8'd5;
    @(negedge clk);
    start8 = 1'b0;
    b2b8(8'd99, 8'd4);
    issue8(8'd200, 8'd7);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_quo", 32'(quo8), 32'd0);
    chk("arst_rem", 32'(rem8), 32'd0);
    chk("arst_flags", {29'd0, busy8, done8, dz8}, 32'd0);
    q8.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue8(8'd9, 8'd4);
    for (int i = 0; i < 300; i++)
      issue8(8'($urandom), (i % 2 == 0) ? 8'($urandom) : 8'($urandom_range(1, 15)));
    issue13(13'd8191, 13'd1);
    issue13(13'd5000, 13'd7);
    issue13(13'd1, 13'd8191);
    issue13(13'd123, 13'd0);
    for (int i = 0; i < 20; i++) issue13(13'($urandom), 13'($urandom_range(1, 8191)));
    n = 0;
    while ((q8.size() != 0 || q13.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain8", 32'(q8.size()), 32'd0);
    chk("drain13", 32'(q13.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
